mips_run_sequencer: RTL and testbench

- Synthesisable run controller that drives the pipelined MIPS core's reset and clock-enable, replacing hand-timed bench reset sequences.
- Holds the core in reset for a parametrised number of cycles, then lets it run.
- Detects program completion, either by reaching a halt address or by the PC stalling in a self-loop, and enforces a cycle budget.
- Sits between the top-level control bundle and the core; reports run status and a cycle count to the bench or top level.

---
 rtl/mips_run_pkg.sv | 21 ++
 rtl/mips_run_halt_detect.sv | 48 ++++
 rtl/mips_run_sequencer.sv | 128 ++++++++++++
 tb/tb_mips_run_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_run_pkg.sv
// Shared types for the MIPS run sequencer: FSM states, default halt PC
// and the run status bundle.
package mips_run_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RSTHOLD,
    RUN,
    DONE,
    TIMEOUT
  } run_state_t;

  localparam logic [31:0] DEFAULT_HALT_ADDR = 32'hFFFF_FFFC;

  typedef struct packed {
    logic running;
    logic done;
    logic timeout;
  } run_status_t;

endpackage

// File: rtl/mips_run_halt_detect.sv
// Program-completion detector: flags a halt when the PC hits the halt address
// or sits on the same value for STALL_CYCLES consecutive comparisons.
module mips_run_halt_detect
  import mips_run_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] HALT_ADDR    = ADDR_W'(DEFAULT_HALT_ADDR),
  parameter int                STALL_CYCLES = 3
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] pcAddr_i,
  output logic              halt_o
);

  localparam int SW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
  localparam logic [SW-1:0] STALL_LAST = (STALL_CYCLES > 0) ? SW'(STALL_CYCLES - 1) : '0;

  logic [ADDR_W-1:0] prev_pc_q;
  logic              prev_vld_q;
  logic [SW-1:0]     stall_q;
  logic              same_pc;
  logic              stall_hit;

  // The first enabled sample of a run has nothing to compare against.
  assign same_pc   = prev_vld_q && (pcAddr_i == prev_pc_q);
  assign stall_hit = (STALL_CYCLES != 0) && same_pc && (stall_q == STALL_LAST);
  assign halt_o    = (pcAddr_i == HALT_ADDR) || stall_hit;

  always_ff @(posedge clock_i) begin
    if (reset_i || clear_i) begin
      prev_pc_q  <= '0;
      prev_vld_q <= 1'b0;
      stall_q    <= '0;
    end else if (en_i) begin
      prev_pc_q  <= pcAddr_i;
      prev_vld_q <= 1'b1;
      if (!same_pc) begin
        stall_q <= '0;
      end else if (stall_q != STALL_LAST) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mips_run_sequencer.sv
// Run controller for the pipelined MIPS core: reset hold, run, halt/timeout.
// Optional single-step gating is enabled with MIPS_RUN_SEQUENCER_STEP_EN.
module mips_run_sequencer
  import mips_run_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                CNT_W        = 32,
  parameter int                RESET_CYCLES = 2,
  parameter int                MAX_CYCLES   = 1000,
  parameter logic [ADDR_W-1:0] HALT_ADDR    = ADDR_W'(DEFAULT_HALT_ADDR),
  parameter int                STALL_CYCLES = 3
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] pcAddr_i,
`ifdef MIPS_RUN_SEQUENCER_STEP_EN
  input  logic              step_i,
  input  logic              stepMode_i,
`endif
  output logic              coreReset_o,
  output logic              coreClockEn_o,
  output logic              running_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [CNT_W-1:0]  cycleCount_o,
  output logic [ADDR_W-1:0] haltPc_o
);

  localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LOAD   = RST_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

  run_state_t        state_q;
  logic [RST_W-1:0]  rst_cnt_q;
  logic              core_reset_q;
  logic              clk_en_q;
  run_status_t       status_q;
  logic [CNT_W-1:0]  cycle_cnt_q;
  logic [ADDR_W-1:0] halt_pc_q;
  logic              run_en;
  logic              halt;

`ifdef MIPS_RUN_SEQUENCER_STEP_EN
  // In step mode the enable follows step within the same cycle so that the
  // core edge and the counted cycle are the same one.
  assign run_en        = !stepMode_i || step_i;
  assign coreClockEn_o = clk_en_q && ((state_q != RUN) || run_en);
`else
  assign run_en        = 1'b1;
  assign coreClockEn_o = clk_en_q;
`endif

  mips_run_halt_detect #(
    .ADDR_W       (ADDR_W),
    .HALT_ADDR    (HALT_ADDR),
    .STALL_CYCLES (STALL_CYCLES)
  ) u_halt_detect (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .clear_i  (state_q != RUN),
    .en_i     ((state_q == RUN) && run_en),
    .pcAddr_i (pcAddr_i),
    .halt_o   (halt)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      rst_cnt_q    <= '0;
      core_reset_q <= 1'b1;
      clk_en_q     <= 1'b0;
      status_q     <= '0;
      cycle_cnt_q  <= '0;
      halt_pc_q    <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, TIMEOUT: begin
          if (start_i) begin
            state_q      <= RSTHOLD;
            rst_cnt_q    <= RST_LOAD;
            cycle_cnt_q  <= '0;
            core_reset_q <= 1'b1;
            clk_en_q     <= 1'b1;
            status_q     <= '0;
          end
        end
        RSTHOLD: begin
          if (rst_cnt_q == '0) begin
            state_q          <= RUN;
            core_reset_q     <= 1'b0;
            status_q.running <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q - 1'b1;
          end
        end
        RUN: begin
          if (run_en) begin
            if (cycle_cnt_q != '1) begin
              cycle_cnt_q <= cycle_cnt_q + 1'b1;
            end
            // Halt outranks budget expiry detected in the same cycle.
            if (halt) begin
              state_q   <= DONE;
              clk_en_q  <= 1'b0;
              status_q  <= '{running: 1'b0, done: 1'b1, timeout: 1'b0};
              halt_pc_q <= pcAddr_i;
            end else if (cycle_cnt_q == LAST_CYCLE) begin
              state_q   <= TIMEOUT;
              clk_en_q  <= 1'b0;
              status_q  <= '{running: 1'b0, done: 1'b0, timeout: 1'b1};
              halt_pc_q <= pcAddr_i;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign coreReset_o  = core_reset_q;
  assign running_o    = status_q.running;
  assign done_o       = status_q.done;
  assign timeout_o    = status_q.timeout;
  assign cycleCount_o = cycle_cnt_q;
  assign haltPc_o     = halt_pc_q;

endmodule

// File: tb/tb_mips_run_sequencer.sv
// Self-checking bench for mips_run_sequencer: table of run patterns, corner
// sequences (restart, mid-run reset, ignored starts) and randomized PC traces.
module tb_mips_run_sequencer;

  localparam int          RESET_C = 2;
  localparam int          MAX_C   = 20;
  localparam int          STALL_C = 3;
  localparam logic [31:0] HALT    = 32'hFFFF_FFFC;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [31:0] pcAddr_i;
  logic        coreReset_o;
  logic        coreClockEn_o;
  logic        running_o;
  logic        done_o;
  logic        timeout_o;
  logic [31:0] cycleCount_o;
  logic [31:0] haltPc_o;
`ifdef MIPS_RUN_SEQUENCER_STEP_EN
  logic        step_i     = 1'b0;
  logic        stepMode_i = 1'b0;
`endif

  always #5 clock_i = ~clock_i;

  mips_run_sequencer #(
    .ADDR_W       (32),
    .CNT_W        (32),
    .RESET_CYCLES (RESET_C),
    .MAX_CYCLES   (MAX_C),
    .HALT_ADDR    (HALT),
    .STALL_CYCLES (STALL_C)
  ) dut (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .pcAddr_i      (pcAddr_i),
`ifdef MIPS_RUN_SEQUENCER_STEP_EN
    .step_i        (step_i),
    .stepMode_i    (stepMode_i),
`endif
    .coreReset_o   (coreReset_o),
    .coreClockEn_o (coreClockEn_o),
    .running_o     (running_o),
    .done_o        (done_o),
    .timeout_o     (timeout_o),
    .cycleCount_o  (cycleCount_o),
    .haltPc_o      (haltPc_o)
  );

  int checks = 0;
  int errors = 0;

  // PC presented in RUN cycle k is pcs[k]; index 0 unused.
  logic [31:0] pcs [0:MAX_C];

  typedef struct {
    int          halt_at;
    int          stick_at;
    bit          exp_done;
    int          exp_cnt;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fill_pattern(input int halt_at, input int stick_at);
    pcs[0] = 32'h0;
    for (int k = 1; k <= MAX_C; k++) begin
      pcs[k] = 32'h100 + 32'(4 * k);
      if (stick_at != 0 && k >= stick_at) pcs[k] = 32'h40;
      if (halt_at != 0 && k == halt_at) pcs[k] = HALT;
    end
  endtask

  // Reference: walk the run, tracking how many consecutive samples repeated.
  function automatic void model(output bit d, output int n, output logic [31:0] hp);
    int same;
    same = 0;
    d    = 1'b0;
    n    = MAX_C;
    hp   = pcs[MAX_C];
    for (int k = 1; k <= MAX_C; k++) begin
      if (k > 1 && pcs[k] == pcs[k-1]) same++;
      else same = 0;
      if (pcs[k] == HALT || (STALL_C > 0 && same >= STALL_C)) begin
        d  = 1'b1;
        n  = k;
        hp = pcs[k];
        return;
      end
    end
  endfunction

  task automatic do_run(input bit ed, input int en, input logic [31:0] ep, input string tag);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk({tag, " start clk_en"}, 64'(coreClockEn_o), 64'd1);
    chk({tag, " start done"}, 64'(done_o), 64'd0);
    chk({tag, " start timeout"}, 64'(timeout_o), 64'd0);
    chk({tag, " start count"}, 64'(cycleCount_o), 64'd0);
    for (int i = 1; i <= RESET_C; i++) begin
      chk({tag, " hold coreReset"}, 64'(coreReset_o), 64'd1);
      chk({tag, " hold running"}, 64'(running_o), 64'd0);
      tick();
    end
    for (int k = 1; k <= en; k++) begin
      pcAddr_i = pcs[k];
      chk({tag, " run running"}, 64'(running_o), 64'd1);
      chk({tag, " run coreReset"}, 64'(coreReset_o), 64'd0);
      chk({tag, " run clk_en"}, 64'(coreClockEn_o), 64'd1);
      chk({tag, " run count"}, 64'(cycleCount_o), 64'(k - 1));
      tick();
    end
    pcAddr_i = 32'h0;
    chk({tag, " end done"}, 64'(done_o), 64'(ed));
    chk({tag, " end timeout"}, 64'(timeout_o), 64'(!ed));
    chk({tag, " end running"}, 64'(running_o), 64'd0);
    chk({tag, " end clk_en"}, 64'(coreClockEn_o), 64'd0);
    chk({tag, " end coreReset"}, 64'(coreReset_o), 64'd0);
    chk({tag, " end count"}, 64'(cycleCount_o), 64'(en));
    chk({tag, " end haltPc"}, 64'(haltPc_o), 64'(ep));
    pcAddr_i = HALT;
    tick();
    tick();
    pcAddr_i = 32'h0;
    chk({tag, " sticky done"}, 64'(done_o), 64'(ed));
    chk({tag, " sticky count"}, 64'(cycleCount_o), 64'(en));
    chk({tag, " sticky haltPc"}, 64'(haltPc_o), 64'(ep));
  endtask

  initial begin
    bit          m_done;
    int          m_cnt;
    logic [31:0] m_pc;
    int          p_same;

    vecs[0] = '{halt_at: 10, stick_at: 0,  exp_done: 1'b1, exp_cnt: 10, exp_pc: HALT};
    vecs[1] = '{halt_at: 0,  stick_at: 5,  exp_done: 1'b1, exp_cnt: 8,  exp_pc: 32'h40};
    vecs[2] = '{halt_at: 0,  stick_at: 0,  exp_done: 1'b0, exp_cnt: 20, exp_pc: 32'h150};
    vecs[3] = '{halt_at: 20, stick_at: 0,  exp_done: 1'b1, exp_cnt: 20, exp_pc: HALT};
    vecs[4] = '{halt_at: 1,  stick_at: 0,  exp_done: 1'b1, exp_cnt: 1,  exp_pc: HALT};
    vecs[5] = '{halt_at: 0,  stick_at: 18, exp_done: 1'b0, exp_cnt: 20, exp_pc: 32'h40};
    vecs[6] = '{halt_at: 0,  stick_at: 17, exp_done: 1'b1, exp_cnt: 20, exp_pc: 32'h40};

    reset_i  = 1'b1;
    start_i  = 1'b0;
    pcAddr_i = 32'h0;
    tick();
    tick();
    tick();
    chk("rst coreReset", 64'(coreReset_o), 64'd1);
    chk("rst clk_en", 64'(coreClockEn_o), 64'd0);
    chk("rst running", 64'(running_o), 64'd0);
    chk("rst done", 64'(done_o), 64'd0);
    chk("rst timeout", 64'(timeout_o), 64'd0);
    chk("rst count", 64'(cycleCount_o), 64'd0);
    chk("rst haltPc", 64'(haltPc_o), 64'd0);
    reset_i = 1'b0;
    tick();
    tick();
    chk("idle coreReset", 64'(coreReset_o), 64'd1);
    chk("idle running", 64'(running_o), 64'd0);

    for (int v = 0; v < 7; v++) begin
      fill_pattern(vecs[v].halt_at, vecs[v].stick_at);
      do_run(vecs[v].exp_done, vecs[v].exp_cnt, vecs[v].exp_pc, $sformatf("vec%0d", v));
    end

    // Starts during RSTHOLD and RUN are ignored; reset mid-run aborts to IDLE.
    fill_pattern(0, 0);
    start_i = 1'b1;
    tick();
    tick();
    start_i = 1'b0;
    chk("hold2 coreReset", 64'(coreReset_o), 64'd1);
    tick();
    chk("run1 coreReset", 64'(coreReset_o), 64'd0);
    chk("run1 running", 64'(running_o), 64'd1);
    for (int k = 1; k <= 7; k++) begin
      pcAddr_i = pcs[k];
      if (k == 3) start_i = 1'b1;
      if (k == 7) reset_i = 1'b1;
      tick();
      start_i = 1'b0;
      if (k == 3) begin
        chk("ign start count", 64'(cycleCount_o), 64'd3);
        chk("ign start running", 64'(running_o), 64'd1);
        chk("ign start coreReset", 64'(coreReset_o), 64'd0);
      end
    end
    reset_i  = 1'b0;
    pcAddr_i = 32'h0;
    chk("abort coreReset", 64'(coreReset_o), 64'd1);
    chk("abort clk_en", 64'(coreClockEn_o), 64'd0);
    chk("abort running", 64'(running_o), 64'd0);
    chk("abort done", 64'(done_o), 64'd0);
    chk("abort timeout", 64'(timeout_o), 64'd0);
    chk("abort count", 64'(cycleCount_o), 64'd0);
    tick();
    tick();
    chk("abort idle coreReset", 64'(coreReset_o), 64'd1);
    chk("abort idle running", 64'(running_o), 64'd0);

    for (int r = 0; r < 40; r++) begin
      p_same = int'($urandom_range(0, 6));
      pcs[0] = 32'h0;
      for (int k = 1; k <= MAX_C; k++) begin
        if (k > 1 && int'($urandom_range(0, 9)) < p_same) pcs[k] = pcs[k-1];
        else if ($urandom_range(0, 29) == 0) pcs[k] = HALT;
        else pcs[k] = ($urandom() & 32'hFFFF_FFFC) | 32'h1000;
      end
      model(m_done, m_cnt, m_pc);
      do_run(m_done, m_cnt, m_pc, $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
